// File: rtl/uart_tx_if.sv
// Byte-stream handshake between the controller's output FSM and the UART transmitter.
// The controller (master) presents a word on tx_data/tx_valid, and the transmitter (slave) reports busy_tx and drives the line.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy_tx;

    modport master (
        output tx_data,
        output tx_valid,
        output par_en,
        output par_typ,
        input  tx_out,
        input  busy_tx
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  par_en,
        input  par_typ,
        output tx_out,
        output busy_tx
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional even/odd parity bit, stop bit.
// tx_out and busy_tx are registered from the current state, so they trail the FSM by one clock.
//
//   state    | meaning
//   S_IDLE   | line high, not busy, waiting for tx_valid
//   S_START  | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA   | data bits LSB first, each CLKS_PER_BIT cycles
//   S_PARITY | latched parity bit (only when par_en was set at acceptance)
//   S_STOP   | stop bit (high), then return to S_IDLE
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input logic      clck,
    input logic      rst,
    uart_tx_if.slave tx_bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [BIT_W-1:0]      bit_idx, bit_idx_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  par_bit, par_bit_nxt;
    logic                  par_on, par_on_nxt;
    logic                  line_nxt;
    logic                  wrap;
    logic                  line_q;
    logic                  busy_q;

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
            par_on  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
            cnt     <= cnt_nxt;
            par_bit <= par_bit_nxt;
            par_on  <= par_on_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        par_bit_nxt = par_bit;
        par_on_nxt  = par_on;
        line_nxt    = 1'b1;
        wrap        = (cnt == CNT_LAST);
        cnt_nxt     = wrap ? '0 : cnt + CNT_W'(1);

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (tx_bus.tx_valid) begin
                    state_nxt   = S_START;
                    shreg_nxt   = tx_bus.tx_data;
                    par_on_nxt  = tx_bus.par_en;
                    par_bit_nxt = (^tx_bus.tx_data) ^ tx_bus.par_typ;
                    bit_idx_nxt = '0;
                end
            end
            S_START: begin
                line_nxt = 1'b0;
                if (wrap) begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                line_nxt = shreg[0];
                if (wrap) begin
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = par_on ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                        shreg_nxt   = shreg >> 1;
                    end
                end
            end
            S_PARITY: begin
                line_nxt = par_bit;
                if (wrap) state_nxt = S_STOP;
            end
            S_STOP: begin
                line_nxt = 1'b1;
                if (wrap) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output flops reset asynchronously so an abort returns the line high without waiting for a clock.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            line_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            line_q <= line_nxt;
            busy_q <= (state != S_IDLE);
        end
    end

    assign tx_bus.tx_out  = line_q;
    assign tx_bus.busy_tx = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two instances (1 and 4 clocks per bit) against a frame-list model.
module tb_uart_tx_serializer;
    logic       clck = 1'b0;
    logic       rst;
    logic [7:0] d_data;
    logic       d_valid, d_pe, d_pt;
    logic       sel;
    logic       obs_line, obs_busy;

    int checks = 0;
    int failures = 0;

    logic cap_line[$];
    logic exp_line[$];
    int   cap_wait;
    logic cap_after;
    logic cap_timeout;

    uart_tx_if #(.DATA_WIDTH(8)) bus1 ();
    uart_tx_if #(.DATA_WIDTH(8)) bus4 ();

    assign bus1.tx_data  = d_data;
    assign bus1.par_en   = d_pe;
    assign bus1.par_typ  = d_pt;
    assign bus1.tx_valid = d_valid & ~sel;
    assign bus4.tx_data  = d_data;
    assign bus4.par_en   = d_pe;
    assign bus4.par_typ  = d_pt;
    assign bus4.tx_valid = d_valid & sel;

    assign obs_line = sel ? bus4.tx_out : bus1.tx_out;
    assign obs_busy = sel ? bus4.busy_tx : bus1.busy_tx;

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clck(clck), .rst(rst), .tx_bus(bus1)
    );
    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clck(clck), .rst(rst), .tx_bus(bus4)
    );

    always #5 clck = ~clck;

    // Expected line sequence while busy: start, data LSB first, optional parity, stop.
    task automatic model_frame(input logic [7:0] data, input logic pe, input logic pt, input int cpb);
        logic p;
        exp_line.delete();
        for (int k = 0; k < cpb; k++) exp_line.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < cpb; k++) exp_line.push_back(data[i]);
        if (pe) begin
            p = (($countones(data) % 2) == 1) ? 1'b1 : 1'b0;
            if (pt) p = ~p;
            for (int k = 0; k < cpb; k++) exp_line.push_back(p);
        end
        for (int k = 0; k < cpb; k++) exp_line.push_back(1'b1);
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_line.size() < exp_line.size()) ? cap_line.size() : exp_line.size();
        for (int i = 0; i < n; i++)
            if (cap_line[i] !== exp_line[i]) return i;
        if (cap_line.size() != exp_line.size()) return n;
        return -1;
    endfunction

    // mode 0: leave tx_valid alone, 1: one-cycle pulse, 2: drop tx_valid when busy_tx is seen
    task automatic capture(input int mode);
        logic done;
        cap_line.delete();
        cap_timeout = 1'b0;
        cap_wait = 0;
        cap_after = 1'bx;
        done = 1'b0;
        while (!done) begin
            @(negedge clck);
            cap_wait++;
            if (obs_busy === 1'b1) done = 1'b1;
            else begin
                if (mode == 1) d_valid = 1'b0;
                if (cap_wait > 50) begin
                    cap_timeout = 1'b1;
                    return;
                end
            end
        end
        if (mode == 2) d_valid = 1'b0;
        cap_line.push_back(obs_line);
        done = 1'b0;
        while (!done) begin
            @(negedge clck);
            if (obs_busy !== 1'b1) begin
                cap_after = obs_line;
                done = 1'b1;
            end else begin
                cap_line.push_back(obs_line);
                if (cap_line.size() > 200) begin
                    cap_timeout = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus1.tx_out !== 1'b1 || bus1.busy_tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut1: got line=%b busy=%b expected line=1 busy=0", bus1.tx_out, bus1.busy_tx);
        end
        checks++;
        if (bus4.tx_out !== 1'b1 || bus4.busy_tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut4: got line=%b busy=%b expected line=1 busy=0", bus4.tx_out, bus4.busy_tx);
        end
        repeat (2) @(negedge clck);
        rst = 1'b0;
        repeat (3) @(negedge clck);
        checks++;
        if (bus1.tx_out !== 1'b1 || bus1.busy_tx !== 1'b0 || bus4.tx_out !== 1'b1 || bus4.busy_tx !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy1=%b busy4=%b expected idle", bus1.busy_tx, bus4.busy_tx);
        end
    endtask

    task automatic test_basic_frames();
        logic [7:0] dat[4] = '{8'hA5, 8'hA5, 8'hA5, 8'h07};
        logic       pe [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       pt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int d;
        sel = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clck);
            d_data = dat[t]; d_pe = pe[t]; d_pt = pt[t]; d_valid = 1'b1;
            capture(1);
            model_frame(dat[t], pe[t], pt[t], 1);
            checks++;
            if (cap_timeout) begin
                failures++;
                $display("FAIL basic_timeout case %0d: no complete frame", t);
            end
            checks++;
            if (cap_wait != 2) begin
                failures++;
                $display("FAIL basic_latency case %0d: got %0d expected 2", t, cap_wait);
            end
            checks++;
            d = first_diff();
            if (d != -1) begin
                failures++;
                $display("FAIL basic_frame case %0d: first diff at %0d, len got %0d expected %0d",
                         t, d, cap_line.size(), exp_line.size());
            end
            checks++;
            if (cap_after !== 1'b1) begin
                failures++;
                $display("FAIL basic_idle_line case %0d: got %b expected 1", t, cap_after);
            end
        end
    endtask

    task automatic test_slow_bit();
        int d;
        sel = 1'b1;
        @(negedge clck);
        d_data = 8'h01; d_pe = 1'b0; d_pt = 1'b0; d_valid = 1'b1;
        capture(1);
        model_frame(8'h01, 1'b0, 1'b0, 4);
        checks++;
        if (cap_timeout || cap_line.size() != 40) begin
            failures++;
            $display("FAIL slow_busy_len: got %0d expected 40", cap_line.size());
        end
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL slow_frame: first diff at %0d got %b expected %b", d,
                     (d < cap_line.size()) ? cap_line[d] : 1'bx, (d < exp_line.size()) ? exp_line[d] : 1'bx);
        end
        checks++;
        if (cap_wait != 2) begin
            failures++;
            $display("FAIL slow_latency: got %0d expected 2", cap_wait);
        end
    endtask

    task automatic test_random();
        logic [7:0] dat;
        logic pe, pt;
        int d;
        for (int t = 0; t < 10; t++) begin
            @(negedge clck);
            sel = t[0];
            dat = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            d_data = dat; d_pe = pe; d_pt = pt; d_valid = 1'b1;
            capture(2);
            model_frame(dat, pe, pt, sel ? 4 : 1);
            d = first_diff();
            checks++;
            if (cap_timeout || d != -1) begin
                failures++;
                $display("FAIL random_frame %0d: data=%h pe=%b pt=%b cpb=%0d diff at %0d timeout=%b",
                         t, dat, pe, pt, sel ? 4 : 1, d, cap_timeout);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        sel = 1'b0;
        @(negedge clck);
        d_data = 8'h3C; d_pe = 1'b0; d_pt = 1'b0; d_valid = 1'b1;
        fork
            begin
                repeat (5) @(negedge clck);
                d_data = 8'hFF;
            end
        join_none
        capture(0);
        model_frame(8'h3C, 1'b0, 1'b0, 1);
        d = first_diff();
        checks++;
        if (cap_timeout || d != -1) begin
            failures++;
            $display("FAIL held_first_frame: diff at %0d timeout=%b", d, cap_timeout);
        end
        capture(2);
        checks++;
        if (cap_wait != 1) begin
            failures++;
            $display("FAIL held_idle_gap: got %0d cycles to busy expected 1", cap_wait);
        end
        model_frame(8'hFF, 1'b0, 1'b0, 1);
        d = first_diff();
        checks++;
        if (cap_timeout || d != -1) begin
            failures++;
            $display("FAIL held_second_frame: diff at %0d timeout=%b", d, cap_timeout);
        end
        d = 0;
        repeat (30) begin
            @(negedge clck);
            if (obs_busy !== 1'b0) d++;
        end
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL held_no_third: got %0d busy cycles expected 0", d);
        end
    endtask

    task automatic test_two_byte();
        int d;
        sel = 1'b1;
        @(negedge clck);
        d_data = 8'h34; d_pe = 1'b1; d_pt = 1'b1; d_valid = 1'b1;
        capture(2);
        model_frame(8'h34, 1'b1, 1'b1, 4);
        d = first_diff();
        checks++;
        if (cap_timeout || d != -1) begin
            failures++;
            $display("FAIL two_byte_low: diff at %0d timeout=%b", d, cap_timeout);
        end
        d_data = 8'h12; d_valid = 1'b1;
        capture(2);
        model_frame(8'h12, 1'b1, 1'b1, 4);
        d = first_diff();
        checks++;
        if (cap_timeout || d != -1 || cap_wait != 2) begin
            failures++;
            $display("FAIL two_byte_high: diff at %0d wait=%0d expected 2 timeout=%b", d, cap_wait, cap_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        sel = 1'b0;
        @(negedge clck);
        d_data = 8'h00; d_pe = 1'b0; d_pt = 1'b0; d_valid = 1'b1;
        @(negedge clck);
        d_valid = 1'b0;
        d = 0;
        while (obs_busy !== 1'b1 && d < 20) begin
            @(negedge clck);
            d++;
        end
        repeat (4) @(negedge clck);
        checks++;
        if (obs_line !== 1'b0 || obs_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit3: got line=%b busy=%b expected line=0 busy=1", obs_line, obs_busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs_line !== 1'b1 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: got line=%b busy=%b expected line=1 busy=0", obs_line, obs_busy);
        end
        @(negedge clck);
        rst = 1'b0;
        d = 0;
        repeat (12) begin
            @(negedge clck);
            if (obs_line !== 1'b1 || obs_busy !== 1'b0) d++;
        end
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL mid_stays_idle: got %0d non-idle cycles expected 0", d);
        end
        d_data = 8'h55; d_valid = 1'b1;
        capture(1);
        model_frame(8'h55, 1'b0, 1'b0, 1);
        d = first_diff();
        checks++;
        if (cap_timeout || d != -1 || cap_wait != 2) begin
            failures++;
            $display("FAIL mid_clean_frame: diff at %0d wait=%0d timeout=%b", d, cap_wait, cap_timeout);
        end
    endtask

    initial begin
        rst = 1'b1;
        d_data = 8'h00; d_valid = 1'b0; d_pe = 1'b0; d_pt = 1'b0;
        sel = 1'b0;
        test_reset();
        test_basic_frames();
        test_slow_bit();
        test_random();
        test_back_to_back();
        test_two_byte();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit end of the byte-stream interface driven by the system controller's output FSM.
- Accepts one 8-bit word per `tx_valid`/`busy_tx` handshake and serializes it onto the UART line: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- `busy_tx` tells the controller when a byte has been taken and when the line is free for the next one.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 1, clck cycles per serial bit (≥1); the bit-period counter width is derived from this.

Ports:
- clck  input  1  system/TX clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- tx_data  input  DATA_WIDTH  parallel byte to send.
- tx_valid  input  1  tx_data is valid; may stay asserted for several cycles.
- par_en  input  1  1 = insert parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- tx_out  output  1  serial line, idles high.
- busy_tx  output  1  high from the cycle after acceptance until the stop bit completes.

Behaviour:
- Reset (async, rst=1):
  - State → IDLE, tx_out=1, busy_tx=0.
  - Shift register, bit counter and period counter → 0.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned and the line returns high at once.
- All outputs are registered; no combinational path from inputs to tx_out or busy_tx.
- Acceptance: on a rising edge in IDLE with tx_valid=1.
  - tx_data, par_en and par_typ are latched.
  - Parity bit = XOR of data (even) or its inverse (odd).
  - Later changes on the inputs do not affect the frame in flight.
- tx_valid while busy_tx=1 (any state other than IDLE) is ignored. A held-high tx_valid is not re-accepted until IDLE is re-entered.
- States:
  - IDLE: tx_out=1, busy_tx=0. tx_valid → START.
  - START: tx_out=0, busy_tx=1, for CLKS_PER_BIT cycles → DATA.
  - DATA: tx_out = data[bit_idx], bit_idx 0..DATA_WIDTH-1, each held CLKS_PER_BIT cycles. After the last bit: par_en=1 → PARITY, else → STOP.
  - PARITY: tx_out = latched parity bit, CLKS_PER_BIT cycles → STOP.
  - STOP: tx_out=1, busy_tx=1, CLKS_PER_BIT cycles → IDLE.
- Period counter: counts 0..CLKS_PER_BIT-1 inside each bit. Bit advance and state transitions happen on the wrap. It resets to 0 on every state entry.
- Latency:
  - tx_out falls (start bit) and busy_tx rises on the first edge after the accepting edge.
  - busy_tx stays high for (10 + par_en)·CLKS_PER_BIT cycles.
- Back-to-back frames:
  - After STOP, at least one IDLE cycle (line high, busy_tx=0) precedes the next frame.
  - If tx_valid is high in that IDLE cycle, the next frame starts on the following edge.
- Controller compatibility:
  - A byte held on tx_data/tx_valid until busy_tx rises is sent exactly once.
  - The falling edge of busy_tx marks line-free for the second byte of a 16-bit result.

Test Plan:
- CLKS_PER_BIT=1, par_en=0, tx_data=0xA5, tx_valid pulsed 1 cycle → tx_out from next cycle: 0,1,0,1,0,0,1,0,1,1; busy_tx high exactly 10 cycles; then tx_out=1, busy_tx=0.
- par_en=1, par_typ=0, tx_data=0xA5 → parity bit 0, frame 11 cycles. par_typ=1 → parity 1. tx_data=0x07, even → parity 1.
- CLKS_PER_BIT=4, tx_data=0x01, par_en=0 → start low 4 cycles, bit0 high 4, bits1–7 low 28, stop high 4; busy_tx high 40 cycles.
- tx_valid held high across a frame, tx_data changed to 0xFF mid-frame → first frame carries original 0x3C unchanged. Exactly one extra frame (0xFF) starts one IDLE cycle after stop; no third frame if tx_valid drops when busy_tx rises.
- Controller-style two-byte send: 0x34 held until busy_tx rises, wait for busy_tx to fall, then 0x12 → two complete frames in order, each fully framed.
- rst asserted during DATA bit 3 → tx_out=1 and busy_tx=0 immediately (before next edge). After release with tx_valid=0, line stays idle. A new tx_valid with 0x55 sends a clean full frame.
